// File: rtl/uart_rx_framed.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : uart_rx_framed                                               |
// | Description : 8N1 UART receiver with synchroniser, false-start rejection,  |
// |               framing-error pulse and a valid/ack holding register with    |
// |               sticky overrun. Define UART_RX_MAJORITY_EN for 2-of-3 votes. |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module uart_rx_framed #(
  parameter int CLKS_PER_BIT = 5
) (
  input  logic       i_Clock,
  input  logic       rst,
  input  logic       i_RX_Serial,
  input  logic       i_RX_Ack,
  output logic       o_RX_Valid,
  output logic [7:0] o_RX_Byte,
  output logic       o_Frame_Err,
  output logic       o_Overrun,
  output logic       o_RX_Busy
);

  localparam logic [15:0] c_MID  = 16'((CLKS_PER_BIT - 1) / 2);
  localparam logic [15:0] c_LAST = 16'(CLKS_PER_BIT - 1);

  localparam logic [2:0] c_IDLE      = 3'd0;
  localparam logic [2:0] c_START     = 3'd1;
  localparam logic [2:0] c_DATA      = 3'd2;
  localparam logic [2:0] c_STOP      = 3'd3;
  localparam logic [2:0] c_WAIT_IDLE = 3'd4;

  logic        r_sync1;
  logic        r_sync2;
  logic        w_bitval;

  logic [2:0]  r_state;
  logic [2:0]  w_state_next;
  logic [15:0] r_count;
  logic [15:0] w_count_next;
  logic [2:0]  r_index;
  logic [2:0]  w_index_next;
  logic [7:0]  r_shift;
  logic [7:0]  w_shift_next;

  logic        w_deliver;
  logic        w_frame_err;

  logic        r_valid;
  logic [7:0]  r_byte;
  logic        r_frame_err;
  logic        r_overrun;
  logic        r_busy;

  // Two-flop synchroniser; idles high so reset never looks like a start bit.
  always_ff @(posedge i_Clock or posedge rst) begin
    if (rst) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= i_RX_Serial;
      r_sync2 <= r_sync1;
    end
  end

`ifdef UART_RX_MAJORITY_EN
  logic [1:0] r_hist;

  always_ff @(posedge i_Clock or posedge rst) begin
    if (rst) begin
      r_hist <= 2'b11;
    end else begin
      r_hist <= {r_hist[0], r_sync2};
    end
  end

  // Vote over the two previous samples plus the current one: no added latency.
  assign w_bitval = (r_hist[1] & r_hist[0]) |
                    (r_hist[1] & r_sync2)   |
                    (r_hist[0] & r_sync2);
`else
  assign w_bitval = r_sync2;
`endif

  always_ff @(posedge i_Clock or posedge rst) begin
    if (rst) begin
      r_state <= c_IDLE;
      r_count <= '0;
      r_index <= '0;
      r_shift <= '0;
    end else begin
      r_state <= w_state_next;
      r_count <= w_count_next;
      r_index <= w_index_next;
      r_shift <= w_shift_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_count_next = r_count;
    w_index_next = r_index;
    w_shift_next = r_shift;
    case (r_state)
      c_IDLE: begin
        w_count_next = '0;
        w_index_next = '0;
        if (!r_sync2) begin
          w_state_next = c_START;
        end
      end
      c_START: begin
        if (r_count == c_MID) begin
          w_count_next = '0;
          w_state_next = w_bitval ? c_IDLE : c_DATA;
        end else begin
          w_count_next = r_count + 16'd1;
        end
      end
      c_DATA: begin
        if (r_count == c_LAST) begin
          w_count_next          = '0;
          w_shift_next[r_index] = w_bitval;
          if (r_index == 3'd7) begin
            w_index_next = '0;
            w_state_next = c_STOP;
          end else begin
            w_index_next = r_index + 3'd1;
          end
        end else begin
          w_count_next = r_count + 16'd1;
        end
      end
      c_STOP: begin
        if (r_count == c_LAST) begin
          w_count_next = '0;
          w_state_next = w_bitval ? c_IDLE : c_WAIT_IDLE;
        end else begin
          w_count_next = r_count + 16'd1;
        end
      end
      c_WAIT_IDLE: begin
        // A held-low line (break) stays here, so it reports only one error.
        w_count_next = '0;
        if (r_sync2) begin
          w_state_next = c_IDLE;
        end
      end
      default: begin
        w_state_next = c_IDLE;
        w_count_next = '0;
        w_index_next = '0;
      end
    endcase
  end

  always_comb begin
    w_deliver   = 1'b0;
    w_frame_err = 1'b0;
    if ((r_state == c_STOP) && (r_count == c_LAST)) begin
      w_deliver   = w_bitval;
      w_frame_err = ~w_bitval;
    end
  end

  // Holding register: a delivery wins over an ack in the same cycle.
  always_ff @(posedge i_Clock or posedge rst) begin
    if (rst) begin
      r_valid     <= 1'b0;
      r_byte      <= 8'h00;
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_frame_err <= w_frame_err;
      r_busy      <= (w_state_next != c_IDLE);
      if (w_deliver) begin
        if (!r_valid || i_RX_Ack) begin
          r_byte  <= r_shift;
          r_valid <= 1'b1;
        end else begin
          r_overrun <= 1'b1;
        end
      end else if (i_RX_Ack && r_valid) begin
        r_valid   <= 1'b0;
        r_overrun <= 1'b0;
      end
    end
  end

  assign o_RX_Valid  = r_valid;
  assign o_RX_Byte   = r_byte;
  assign o_Frame_Err = r_frame_err;
  assign o_Overrun   = r_overrun;
  assign o_RX_Busy   = r_busy;

endmodule
`default_nettype wire

// File: doc/uart_rx_framed.md
# uart_rx_framed

- Asynchronous serial receiver: 8 data bits, LSB first, one start bit, one stop bit, no parity.
- Pairs with the existing `UART_TX` on the system-control UART link and uses the same `CLKS_PER_BIT` timing.
- Adds input synchronisation, false-start rejection, framing-error detection and a one-entry holding register with valid/ack handshake and overrun flag, so host logic can consume bytes at its own pace.

## Interface
- `CLKS_PER_BIT`, default 5: clocks per serial bit; legal range 3..65535.
- `i_Clock`, in, 1: sole clock, rising edge.
- `rst`, in, 1: reset; asynchronous, active-high.
- `i_RX_Serial`, in, 1: serial line, idle high, asynchronous to `i_Clock`.
- `i_RX_Ack`, in, 1: consumer has taken `o_RX_Byte`.
- `o_RX_Valid`, out, 1: `o_RX_Byte` holds an unconsumed byte.
- `o_RX_Byte`, out, 8: received byte.
- `o_Frame_Err`, out, 1: one-cycle pulse, stop bit sampled low.
- `o_Overrun`, out, 1: sticky; a completed byte was dropped.
- `o_RX_Busy`, out, 1: high in any state other than IDLE.

## Operation
- **Synchroniser:** 2 flops on `i_RX_Serial`; the second flop output is `s`. A 3-bit history `h` holds `s` at t-2, t-1 and t. All three reset to 1.
- **Sample value:** `bitval` = majority(`h`) when the macro is defined, else `s`.
- **Constants:** `MID` = (`CLKS_PER_BIT`-1)/2, integer division. The bit counter is 16 bits; the bit index is 3 bits.
- **IDLE:** count=0, index=0. If `s`==0, go to START.
- **START:** count increments each cycle. When count==`MID`:
  - `bitval`==0: go to DATA, count=0.
  - `bitval`==1: go to IDLE (false start, no outputs touched).
- **DATA:** count increments each cycle. When count==`CLKS_PER_BIT`-1:
  - shift register[index] <= `bitval`, count=0.
  - index<7: index+1, stay in DATA.
  - index==7: index=0, go to STOP.
- **STOP:** when count==`CLKS_PER_BIT`-1:
  - `bitval`==1: deliver the byte, go to IDLE.
  - `bitval`==0: `o_Frame_Err`=1 for one cycle, byte discarded, go to WAIT_IDLE.
- **WAIT_IDLE:** stay until `s`==1, then go to IDLE. A held-low line (break) produces exactly one error.
- **Delivery:** `o_RX_Byte` is loaded only by a delivery that is accepted.
  - Deliver with `o_RX_Valid`==0: load byte, `o_RX_Valid`<=1.
  - Deliver with `o_RX_Valid`==1 and `i_RX_Ack`==1 in the same cycle: load new byte, valid stays 1, no overrun.
  - Deliver with `o_RX_Valid`==1 and `i_RX_Ack`==0: new byte dropped, old byte kept, `o_Overrun`<=1.
- **Acknowledge:** `i_RX_Ack`==1 while valid and no delivery in that cycle: `o_RX_Valid`<=0 and `o_Overrun`<=0. `i_RX_Ack` while not valid is ignored.
- **Encodings:** unused state encodings go to IDLE.

## Timing
- **Reset values:** all outputs 0 (`o_RX_Byte`=0x00); state IDLE; counters 0; synchroniser and history 1. Reset mid-frame aborts the frame with no partial delivery.
- **Latency:** let E0 be the clock edge that first samples `i_RX_Serial` low.
  - START entered after E2.
  - Start decision at E(3+`MID`).
  - Data bit k decided at E(3+`MID`+(k+1)·`CLKS_PER_BIT`).
  - Stop decision and `o_RX_Valid` rising at E(3+`MID`+9·`CLKS_PER_BIT`): 50 cycles for `CLKS_PER_BIT`=5.
- **Majority:** adds no latency; it uses the past two samples.
- **Ack:** `o_RX_Valid` falls the cycle after `i_RX_Ack` is sampled high.
- **Outputs:** `o_Frame_Err` is high in the cycle after the failing stop decision only. `o_RX_Busy` is registered from state.
- **Back-to-back frames:** the next start bit may begin in the cycle after the stop decision.

## Configuration
- Macro: `UART_RX_MAJORITY_EN`.
- **Defined:** start, data and stop decisions use the 2-of-3 majority over the last three synchronised samples.
- **Undefined:** decisions use the single synchronised sample `s`; the history register is removed.
- **Either way:** state machine, latency and handshake are identical.

## Test plan
All scenarios use `CLKS_PER_BIT`=5.
- **Single byte:** serialise 0xA5 with a valid stop bit, no ack -> `o_RX_Valid`=1 at E0+50, `o_RX_Byte`=0xA5, `o_Frame_Err`=0, `o_Overrun`=0; ack -> valid 0 next cycle.
- **Glitch rejection:** 1-cycle low pulse on an idle line -> `o_RX_Busy` high ≤5 cycles then back to IDLE; no valid, no error.
- **Framing error:** send 0x3C with stop bit low, line held low 30 cycles -> one `o_Frame_Err` pulse, `o_RX_Valid` stays 0. Line high then 0x3C sent correctly -> 0x3C delivered.
- **Overrun:** send 0x11 then 0x22 back-to-back, no ack -> `o_RX_Byte`=0x11, `o_Overrun`=1. Repeat with ack asserted in the cycle 0x22 completes -> `o_RX_Byte`=0x22, `o_Overrun`=0.
- **Majority:** send 0x00 with a 1-cycle high pulse centred on bit 3's decision point -> with macro 0x00; without macro 0x08.
- **Reset mid-frame:** assert `rst` during bit 4 of 0xFF -> all outputs 0 immediately. Release, send 0x5A -> 0x5A delivered at E0+50.
